logical_unit: RTL and testbench
===============================

// Module: logical_unit
// PURPOSE
//   Bitwise logic execution unit of the RISC-V integer ALU.
//   Serves AND/ANDI, OR/ORI and XOR/XORI; selection is by funct3[1:0].
//   Result is combinational so it is usable in the same execute cycle.
//   A registered copy with a valid flag is also provided for pipelined consumers.
// PARAMETERS
//   XLEN  32  operand and result width in bits
// PORTS
//   CLK         in   1     system clock; rising edge active
//   rst_n       in   1     asynchronous active-low reset
//   Rs1         in   XLEN  operand A (rs1 value)
//   Rs2         in   XLEN  operand B (rs2 value or sign-extended immediate)
//   funct3_1_0  in   2     operation select, instruction funct3[1:0]
//   En          in   1     unit enable from the ALU decoder
//   Result      out  XLEN  combinational result
//   Result_q    out  XLEN  Result registered on CLK
//   Valid_q     out  1     Result_q holds a result from an enabled cycle
//   Zero        out  1     combinational; 1 when Result == 0
// BEHAVIOUR
//   Interface: one clock (CLK); reset is asynchronous and active-low (rst_n).
//   Operation decode when En=1:
//     2'b11 AND : Result = Rs1 & Rs2
//     2'b10 OR  : Result = Rs1 | Rs2
//     2'b00 XOR : Result = Rs1 ^ Rs2
//     2'b01     : Result = 0 (unused encoding; no X propagation)
//   When En=0, Result = 0 regardless of the other inputs.
//   Result and Zero are purely combinational, with zero-cycle latency.
//     They settle within the same cycle as any input change.
//     They are independent of CLK and rst_n.
//   All operations are bitwise: no carry, no sign handling, width XLEN throughout.
//   Registered path:
//     rst_n low, at any time and asynchronously: Result_q = 0, Valid_q = 0.
//     Rising CLK edge with En=1: Result_q <= Result, Valid_q <= 1.
//     Rising CLK edge with En=0: Result_q holds its value, Valid_q <= 0.
//     One-cycle latency from inputs to Result_q.
//     On reset deassertion, the first update occurs at the next rising CLK edge.
//     Reset asserted mid-operation clears the registers immediately.
//       The combinational Result is unaffected.
//   X/Z on funct3_1_0 while En=1 must not generate latches.
//     A full case with a default of 0 is required.
// TESTING
//   Directed scenarios:
//   1. En=1, funct3=11, Rs1=F0F0_F0F0, Rs2=FF00_FF00
//        -> Result=F000_F000 within the same delta/cycle
//   2. En=1, funct3=10, Rs1=0000_00FF, Rs2=1234_0000
//        -> Result=1234_00FF, Zero=0
//   3. En=1, funct3=00, Rs1=Rs2=DEAD_BEEF
//        -> Result=0, Zero=1
//   4. En=1, funct3=01, any operands -> Result=0.
//      En=0 with funct3=11, Rs1=Rs2=FFFF_FFFF -> Result=0.
//   5. Registered path:
//        rst_n=0 -> Result_q=0 and Valid_q=0 without a clock edge.
//        Release reset; apply En=1 AND with FFFF_0000 and 0F0F_0F0F.
//        Next edge -> Result_q=0F0F_0000, Valid_q=1.
//        En=0 on the next edge -> Result_q holds, Valid_q=0.
//   6. Random regression: 20+ random Rs1/Rs2/funct3 with En=1.
//        Compare Result with === against the reference model.
//        The reference model returns 0 for encoding 01.

Source files
------------

// File: rtl/logical_unit_if.sv
// Operand/result bundle between the ALU decoder and the bitwise logic unit.
// Signal names follow the ALU datapath naming so waveforms line up with the decoder.
interface logical_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] Rs1;
  logic [XLEN-1:0] Rs2;
  logic [1:0]      funct3_1_0;
  logic            En;
  logic [XLEN-1:0] Result;
  logic [XLEN-1:0] Result_q;
  logic            Valid_q;
  logic            Zero;

  modport master (
    output Rs1, Rs2, funct3_1_0, En,
    input  Result, Result_q, Valid_q, Zero
  );

  modport slave (
    input  Rs1, Rs2, funct3_1_0, En,
    output Result, Result_q, Valid_q, Zero
  );
endinterface

// File: rtl/logical_unit.sv
// Bitwise AND/OR/XOR execution unit of the integer ALU.
// Combinational result for same-cycle use, plus a registered copy with a valid flag.
module logical_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic          CLK,
  input  logic          rst_n,
  logical_unit_if.slave bus
);

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  logic [XLEN-1:0] result_c;
  logic [XLEN-1:0] result_d, result_q;
  logic            valid_d,  valid_q;

  // Operation decode; unused encoding and disabled unit both yield zero
  always_comb begin
    result_c = '0;
    if (bus.En) begin
      case (bus.funct3_1_0)
        OP_AND:  result_c = bus.Rs1 & bus.Rs2;
        OP_OR:   result_c = bus.Rs1 | bus.Rs2;
        OP_XOR:  result_c = bus.Rs1 ^ bus.Rs2;
        default: result_c = '0;
      endcase
    end
  end

  // Result register holds while disabled; valid tracks the enable of the last edge
  always_comb begin
    result_d = result_q;
    valid_d  = bus.En;
    if (bus.En) begin
      result_d = result_c;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.Result   = result_c;
  assign bus.Zero     = (result_c == '0);
  assign bus.Result_q = result_q;
  assign bus.Valid_q  = valid_q;

endmodule

// File: tb/tb_logical_unit.sv
// Self-checking bench for logical_unit: directed vector table, registered-path
// sequences including mid-cycle reset, and a randomized regression against a model.
module tb_logical_unit;

  localparam int unsigned XLEN = 32;

  logic CLK;
  logic rst_n;

  logical_unit_if #(.XLEN(XLEN)) bus ();

  logical_unit #(.XLEN(XLEN)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            en;
    logic [1:0]      f3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] exp_result;
    logic            exp_zero;
  } vec_t;

  // Reference: per-bit truth table lookup chosen by the operation
  function automatic logic [XLEN-1:0] ref_logic(input logic en, input logic [1:0] f3,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [3:0]      tt;
    logic [XLEN-1:0] r;
    r = '0;
    if (!en) return r;
    case (f3)
      2'b11:   tt = 4'b1000;
      2'b10:   tt = 4'b1110;
      2'b00:   tt = 4'b0110;
      default: tt = 4'b0000;
    endcase
    for (int i = 0; i < int'(XLEN); i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.En         = en;
    bus.funct3_1_0 = f3;
    bus.Rs1        = a;
    bus.Rs2        = b;
  endtask

  vec_t            vecs[$];
  logic [XLEN-1:0] exp_q;
  logic            exp_v;
  logic            r_en;
  logic [1:0]      r_f3;
  logic [XLEN-1:0] r_a, r_b, r_exp;

  initial begin
    vecs.push_back('{1'b1, 2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 32'h0000_00FF, 32'h1234_0000, 32'h1234_00FF, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 2'b01, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 2'b11, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0});

    rst_n = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    #3;
    check("reset_result_q", bus.Result_q, '0);
    check("reset_valid_q", XLEN'(bus.Valid_q), '0);

    // Combinational vectors (independent of reset)
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].f3, vecs[i].rs1, vecs[i].rs2);
      #1;
      check($sformatf("vec%0d_result", i), bus.Result, vecs[i].exp_result);
      check($sformatf("vec%0d_zero", i), XLEN'(bus.Zero), XLEN'(vecs[i].exp_zero));
    end
    check("reset_hold_result_q", bus.Result_q, '0);

    // Registered path: AND then a disabled cycle
    @(negedge CLK);
    rst_n = 1'b1;
    drive(1'b1, 2'b11, 32'hFFFF_0000, 32'h0F0F_0F0F);
    @(posedge CLK); #1;
    check("reg_and_result_q", bus.Result_q, 32'h0F0F_0000);
    check("reg_and_valid_q", XLEN'(bus.Valid_q), 1);
    drive(1'b0, 2'b10, 32'h1111_1111, 32'h2222_2222);
    @(posedge CLK); #1;
    check("reg_hold_result_q", bus.Result_q, 32'h0F0F_0000);
    check("reg_hold_valid_q", XLEN'(bus.Valid_q), 0);
    check("reg_hold_result_comb", bus.Result, '0);

    // Mid-cycle reset clears registers without an edge; Result unaffected
    drive(1'b1, 2'b10, 32'h00F0_0000, 32'h0000_000F);
    @(posedge CLK); #1;
    check("pre_rst_result_q", bus.Result_q, 32'h00F0_000F);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_result_q", bus.Result_q, '0);
    check("mid_rst_valid_q", XLEN'(bus.Valid_q), 0);
    check("mid_rst_result_comb", bus.Result, 32'h00F0_000F);
    @(negedge CLK);
    rst_n = 1'b1;
    #1;
    check("post_rel_result_q", bus.Result_q, '0);
    @(posedge CLK); #1;
    check("first_edge_result_q", bus.Result_q, 32'h00F0_000F);
    check("first_edge_valid_q", XLEN'(bus.Valid_q), 1);

    // Randomized regression against the model, including registered path
    exp_q = bus.Result_q;
    exp_v = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r_en = (n < 24) ? 1'b1 : ($urandom_range(0, 3) != 0);
      r_f3 = 2'($urandom_range(0, 3));
      r_a  = $urandom();
      r_b  = (n % 7 == 0) ? r_a : $urandom();
      drive(r_en, r_f3, r_a, r_b);
      #1;
      r_exp = ref_logic(r_en, r_f3, r_a, r_b);
      check($sformatf("rnd%0d_result", n), bus.Result, r_exp);
      check($sformatf("rnd%0d_zero", n), XLEN'(bus.Zero), XLEN'(r_exp == '0));
      @(posedge CLK); #1;
      if (r_en) exp_q = r_exp;
      exp_v = r_en;
      check($sformatf("rnd%0d_result_q", n), bus.Result_q, exp_q);
      check($sformatf("rnd%0d_valid_q", n), XLEN'(bus.Valid_q), XLEN'(exp_v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
